uart_rx: RTL

Oversampling UART receiver: the receive-side counterpart of the UART transmitter in the same multi-clock system. It samples the serial line at `prescale` times the baud rate and recovers each frame:

- start bit, DATA_WIDTH data bits LSB-first, optional parity bit, one stop bit.
- Each bit is resolved by 3-sample majority vote.
- Parity and stop bits are checked, then the byte is presented to the register/data-sync stage with a single-cycle valid pulse.

It runs in the UART RX clock domain; clk must equal prescale × baud.

---
 rtl/uart_rx.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with 3-sample majority vote, parity and stop checking
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [5:0]            prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state;
  state_t                state_nxt;

  logic [5:0]            edge_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  par_flag;
  logic                  samp_a;
  logic                  samp_b;
  logic                  sampled_bit;

  logic [5:0]            last_edge;
  logic [5:0]            mid_edge;
  logic                  end_of_bit;
  logic                  last_data_bit;
  logic                  par_expected;
  logic                  frame_done;
  logic                  start_seen;

  logic                  valid_d;
  logic                  par_err_d;
  logic                  stp_err_d;

  // Bit-period geometry derived from the oversampling ratio. The three
  // samples straddle the centre of the bit; the decision waits for the
  // last edge so the registered majority is settled by then.
  assign last_edge     = prescale - 6'd1;
  assign mid_edge      = {1'b0, prescale[5:1]};
  assign end_of_bit    = (state != IDLE) && (edge_cnt == last_edge);
  assign last_data_bit = (bit_cnt == BW'(DATA_WIDTH - 1));
  assign par_expected  = (^shift_reg) ^ par_typ;
  assign frame_done    = (state == STOP) && end_of_bit;
  assign start_seen    = (state == IDLE) && !rx_in;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; every transition out of a frame state happens at end-of-bit.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!rx_in) begin
          state_nxt = START;
        end
      end
      START: begin
        if (end_of_bit) begin
          // A start bit that votes high was a glitch on the line.
          state_nxt = sampled_bit ? IDLE : DATA;
        end
      end
      DATA: begin
        if (end_of_bit && last_data_bit) begin
          state_nxt = par_en ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (end_of_bit) begin
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (end_of_bit) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Frame result decode; the pulses are registered below so they land one cycle after the stop bit ends.
  always_comb begin
    valid_d   = 1'b0;
    par_err_d = 1'b0;
    stp_err_d = 1'b0;
    if (frame_done) begin
      stp_err_d = !sampled_bit;
      par_err_d = par_flag;
      valid_d   = sampled_bit && !par_flag;
    end
  end

  // Output registers: single-cycle pulses, p_data only moves on a clean frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      p_data     <= '0;
    end else begin
      data_valid <= valid_d;
      par_err    <= par_err_d;
      stp_err    <= stp_err_d;
      if (valid_d) begin
        p_data <= shift_reg;
      end
    end
  end

  // Edge and bit counters. The detection cycle is edge 0, so the counter
  // starts at 1 when leaving IDLE and is parked at 0 while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (state == IDLE) begin
      edge_cnt <= rx_in ? 6'd0 : 6'd1;
      bit_cnt  <= '0;
    end else begin
      if (end_of_bit) begin
        edge_cnt <= '0;
      end else begin
        edge_cnt <= edge_cnt + 6'd1;
      end
      if (end_of_bit && (state == START)) begin
        bit_cnt <= '0;
      end else if (end_of_bit && (state == DATA)) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // Three samples around mid-bit; the third one resolves the majority into sampled_bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      samp_a      <= 1'b0;
      samp_b      <= 1'b0;
      sampled_bit <= 1'b0;
    end else if (state != IDLE) begin
      if (edge_cnt == mid_edge - 6'd1) begin
        samp_a <= rx_in;
      end
      if (edge_cnt == mid_edge) begin
        samp_b <= rx_in;
      end
      if (edge_cnt == mid_edge + 6'd1) begin
        sampled_bit <= (samp_a & samp_b) | (samp_a & rx_in) | (samp_b & rx_in);
      end
    end
  end

  // Data shift register (LSB arrives first) and sticky parity mismatch for the current frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg <= '0;
      par_flag  <= 1'b0;
    end else begin
      if ((state == DATA) && end_of_bit) begin
        shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
      end
      if (start_seen) begin
        par_flag <= 1'b0;
      end else if ((state == PARITY) && end_of_bit && (sampled_bit != par_expected)) begin
        par_flag <= 1'b1;
      end
    end
  end

endmodule
